// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter for the async-FIFO read port: hands rdata to one consumer at a time in bursts of up to BURST words.
// Latency: req to grant 1 edge, grant to first pop 1 cycle, pop to out_valid 1 edge (minimum 2 edges req to out_valid).
// Backpressure: a pop is issued only when the output register is empty or being accepted the same cycle, so ready low stalls the FIFO.
module rd_port_arbiter #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  ready,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_data,
  output logic [NREQ-1:0]  out_gnt,
  output logic [IDW-1:0]   out_id
);

  // Counter is wide enough to hold BURST itself so it can saturate there.
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last_win;

  logic [IDW-1:0] pick_id;
  logic           pick_hit;
  logic [IDW-1:0] cand;
  logic           accept;
  logic           cnt_room;
  logic           out_free;
  logic           last_pop;

  // Round-robin search: first requester strictly after the previous winner, wrapping.
  always_comb begin
    pick_id  = '0;
    pick_hit = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_win) + i) % NREQ);
      if (!pick_hit && req[cand]) begin
        pick_hit = 1'b1;
        pick_id  = cand;
      end
    end
  end

  // Only the granted consumer's ready counts; everyone else's is ignored.
  assign accept   = out_valid & ready[out_id];
  assign cnt_room = (cnt < BMAX);
  assign out_free = !out_valid | accept;

  // Pop strobe is combinational so it can drop in the same cycle rempty rises.
  // rrst_n gates it so no pop escapes while the block is held in reset.
  assign rinc = rrst_n & (state == S_BURST) & !rempty & req[out_id] & out_free & cnt_room;

  // This pop fills the burst quota, so the burst closes on this edge.
  assign last_pop = rinc & ((cnt + CW'(1)) == BMAX);

  // Grant FSM, burst counter and output register.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_win  <= IDW'(NREQ - 1);
      out_gnt   <= '0;
      out_id    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_hit) begin
            out_gnt  <= {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
            out_id   <= pick_id;
            last_win <= pick_id;
            cnt      <= '0;
            state    <= S_BURST;
          end
        end

        S_BURST: begin
          if (rinc) begin
            out_data  <= rdata;
            out_valid <= 1'b1;
            cnt       <= cnt + CW'(1);
          end else if (accept) begin
            out_valid <= 1'b0;
          end
          // Close the burst on quota or when the consumer lets go; an empty
          // FIFO with the request still held just waits here.
          if (last_pop || !req[out_id] || !cnt_room) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // Keep the grant until any pending word has been taken.
          if (out_free) begin
            out_valid <= 1'b0;
            out_gnt   <= '0;
            out_id    <= '0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          out_gnt   <= '0;
          out_id    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter: queue-based FIFO model feeding rempty/rdata, delivery log of accepted words.
// Inputs change on the falling edge; rinc/accept are sampled 1 time unit later and outputs after the falling edge.
// Expected values are hand-derived cycle by cycle for DSIZE=8, NREQ=4, BURST=4.
module tb_rd_port_arbiter;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [3:0] req;
  logic [3:0] ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] out_gnt;
  logic [1:0] out_id;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] fq[$];
  logic [1:0] dq_id[$];
  logic [7:0] dq_dat[$];
  logic       last_rinc;
  logic       last_acc;
  logic [31:0] pat;

  always #5 rclk = ~rclk;

  rd_port_arbiter #(.DSIZE(8), .NREQ(4), .IDW(2), .BURST(4)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .req       (req),
    .ready     (ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_gnt   (out_gnt),
    .out_id    (out_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present FIFO state, observe pop/accept, advance one edge.
  task automatic tick();
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
    #1;
    last_rinc = rinc;
    last_acc  = rrst_n && out_valid && ready[out_id];
    if (last_rinc) begin
      chk("rinc_nonempty", {31'b0, rempty}, 32'd0);
      if (fq.size() != 0) void'(fq.pop_front());
    end
    if (last_acc) begin
      dq_id.push_back(out_id);
      dq_dat.push_back(out_data);
    end
    @(posedge rclk);
    @(negedge rclk);
    chk("onehot", {31'b0, ($countones(out_gnt) <= 1)}, 32'd1);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    tick();
    tick();
    rrst_n = 1'b1;
    fq.delete();
    dq_id.delete();
    dq_dat.delete();
  endtask

  initial begin
    rrst_n = 1'b0;
    rempty = 1'b1;
    rdata  = 8'h00;
    req    = 4'b0000;
    ready  = 4'b0000;
    @(negedge rclk);

    // ---------------- Reset with FIFO loaded and all requesting ----------------
    for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    req   = 4'b1111;
    ready = 4'b1111;
    rrst_n = 1'b0;
    tick();
    chk("rst_rinc0", {31'b0, last_rinc}, 32'd0);
    tick();
    chk("rst_rinc1", {31'b0, last_rinc}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_gnt", {28'b0, out_gnt}, 32'd0);
    chk("rst_id", {30'b0, out_id}, 32'd0);
    chk("rst_fifo_untouched", fq.size(), 32'd16);

    // ---------------- Rotation: 16 words, bursts of 4 ----------------
    rrst_n = 1'b1;
    pat = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      pat[i] = last_rinc;
      if (i == 0) chk("first_gnt", {28'b0, out_gnt}, 32'h1);
      if (i == 6) chk("second_gnt", {28'b0, out_gnt}, 32'h2);
    end
    chk("rot_rinc_pattern", pat, 32'h0079E79E);
    chk("rot_count", dq_dat.size(), 32'd16);
    for (int i = 0; i < 16 && i < dq_dat.size(); i++) begin
      chk("rot_data", {24'b0, dq_dat[i]}, 32'(i));
      chk("rot_id", {30'b0, dq_id[i]}, 32'(i / 4));
    end

    // ---------------- Backpressure on consumer 2 ----------------
    req = 4'b0000;
    do_reset();
    fq.push_back(8'hA0); fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    req   = 4'b0100;
    ready = 4'b0000;
    tick();
    chk("bp_gnt", {28'b0, out_gnt}, 32'h4);
    chk("bp_id", {30'b0, out_id}, 32'd2);
    tick();
    chk("bp_first_pop", {31'b0, last_rinc}, 32'd1);
    chk("bp_first_data", {24'b0, out_data}, 32'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_rinc", {31'b0, last_rinc}, 32'd0);
      chk("bp_stall_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_stall_data", {24'b0, out_data}, 32'hA0);
    end
    ready = 4'b0100;
    tick();
    chk("bp_resume_pop", {31'b0, last_rinc}, 32'd1);
    chk("bp_resume_acc", {31'b0, last_acc}, 32'd1);
    chk("bp_resume_data", {24'b0, out_data}, 32'hA1);
    chk("bp_resume_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_deliv", (dq_dat.size() == 1) ? {22'b0, dq_id[0], dq_dat[0]} : 32'hFFFF_FFFF, 32'h2A0);

    // ---------------- FIFO empties mid-burst ----------------
    req = 4'b0000;
    do_reset();
    fq.push_back(8'hB0); fq.push_back(8'hB1);
    req   = 4'b0010;
    ready = 4'b0010;
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat[i] = last_rinc;
    end
    chk("emp_gnt_held", {28'b0, out_gnt}, 32'h2);
    fq.push_back(8'hB2);
    tick();
    pat[5] = last_rinc;
    chk("emp_rinc_pattern", pat, 32'h26);
    chk("emp_third_data", {24'b0, out_data}, 32'hB2);
    req = 4'b0000;
    tick();
    tick();
    chk("emp_release_gnt", {28'b0, out_gnt}, 32'h0);
    chk("emp_count", dq_dat.size(), 32'd3);
    for (int i = 0; i < 3 && i < dq_dat.size(); i++) begin
      chk("emp_data", {24'b0, dq_dat[i]}, 32'hB0 + 32'(i));
      chk("emp_id", {30'b0, dq_id[i]}, 32'd1);
    end

    // ---------------- Early release in DRAIN, then skip to consumer 2 ----------------
    do_reset();
    fq.push_back(8'hC0); fq.push_back(8'hC1); fq.push_back(8'hC2); fq.push_back(8'hC3);
    req   = 4'b0101;
    ready = 4'b0000;
    tick();
    chk("er_gnt0", {28'b0, out_gnt}, 32'h1);
    tick();
    chk("er_pop", {31'b0, last_rinc}, 32'd1);
    req = 4'b0100;
    tick();
    chk("er_drop_rinc", {31'b0, last_rinc}, 32'd0);
    chk("er_drop_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("er_drain_gnt", {28'b0, out_gnt}, 32'h1);
    chk("er_drain_data", {24'b0, out_data}, 32'hC0);
    ready = 4'b0001;
    tick();
    chk("er_release_gnt", {28'b0, out_gnt}, 32'h0);
    chk("er_release_valid", {31'b0, out_valid}, 32'd0);
    chk("er_deliv", (dq_dat.size() == 1) ? {22'b0, dq_id[0], dq_dat[0]} : 32'hFFFF_FFFF, 32'h0C0);
    req   = 4'b0101;
    ready = 4'b0000;
    tick();
    chk("er_skip_gnt", {28'b0, out_gnt}, 32'h4);
    chk("er_skip_id", {30'b0, out_id}, 32'd2);
    tick();
    chk("er_c2_valid", {31'b0, out_valid}, 32'd1);
    chk("er_c2_data", {24'b0, out_data}, 32'hC1);

    // ---------------- Reset mid-burst restores the pointer ----------------
    rrst_n = 1'b0;
    req    = 4'b1111;
    tick();
    chk("mr_rinc", {31'b0, last_rinc}, 32'd0);
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_gnt", {28'b0, out_gnt}, 32'h0);
    chk("mr_id", {30'b0, out_id}, 32'd0);
    rrst_n = 1'b1;
    tick();
    chk("mr_first_gnt", {28'b0, out_gnt}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
